dpu_pipe: RTL and testbench



---
 rtl/dpu_pipe_if.sv | 27 ++
 rtl/dpu_pipe.sv | 145 ++++++++++++++
 tb/tb_dpu_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dpu_pipe_if.sv
// Issue/result bundle between the CCU sequencer (master) and the pipelined
// datapath unit (slave); Kbus, cc and out_valid flow back to the master.
interface dpu_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned K_REGS = 3
) ();
  logic                       in_valid;
  logic [AW-1:0]              Abus;
  logic [AW-1:0]              Bbus;
  logic [AW-1:0]              Rbus;
  logic [3:0]                 n;
  logic [DATA_W-1:0]          mData;
  logic [DATA_W*K_REGS-1:0]   Kbus;
  logic [3:0]                 cc;
  logic                       out_valid;

  modport master (
    output in_valid, Abus, Bbus, Rbus, n, mData,
    input  Kbus, cc, out_valid
  );

  modport slave (
    input  in_valid, Abus, Bbus, Rbus, n, mData,
    output Kbus, cc, out_valid
  );
endinterface

// File: rtl/dpu_pipe.sv
// Two-stage register-file/ALU datapath: issue+execute into E, then writeback.
// E results are forwarded to the next issuing op; constant registers are never written.
module dpu_pipe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NREG     = 16,
  parameter int unsigned K_BASE   = 9,
  parameter int unsigned K_REGS   = 3,
  parameter int unsigned ZERO_IDX = 13,
  parameter int unsigned ONE_IDX  = 12
) (
  input logic         clk,
  input logic         rst_n,
  dpu_pipe_if.slave   bus
);
  localparam int unsigned AW  = $clog2(NREG);
  localparam int unsigned MSB = DATA_W - 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_LOAD = 4'd8,
    OP_MOV  = 4'd9
  } op_e;

  logic [DATA_W-1:0] r_q [NREG];

  logic              e_valid_q, e_wr_q, e_ccupd_q;
  logic [AW-1:0]     e_rd_q;
  logic [DATA_W-1:0] e_res_q;
  logic [3:0]        e_flags_q;

  logic [3:0]        cc_q;
  logic              out_valid_q;

  logic              fwd_a, fwd_b, const_dst;
  logic [DATA_W-1:0] opa, opb, res_d;
  logic              c_d, v_d, wr_d, ccupd_d;
  logic [3:0]        flags_d;

  // e_wr_q already excludes constant destinations, so the bypass can never
  // hand out a value the register file is going to discard.
  always_comb begin
    fwd_a = e_valid_q && e_wr_q && (e_rd_q == bus.Abus);
    fwd_b = e_valid_q && e_wr_q && (e_rd_q == bus.Bbus);
    opa   = fwd_a ? e_res_q : r_q[bus.Abus];
    opb   = fwd_b ? e_res_q : r_q[bus.Bbus];
    const_dst = (bus.Rbus == AW'(ZERO_IDX)) || (bus.Rbus == AW'(ONE_IDX));
  end

  always_comb begin
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    wr_d    = 1'b1;
    ccupd_d = 1'b1;
    case (bus.n)
      OP_ADD: begin
        {c_d, res_d} = {1'b0, opa} + {1'b0, opb};
        v_d = (opa[MSB] == opb[MSB]) && (res_d[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        {c_d, res_d} = {1'b0, opa} - {1'b0, opb};
        v_d = (opa[MSB] != opb[MSB]) && (res_d[MSB] != opa[MSB]);
      end
      OP_AND: res_d = opa & opb;
      OP_OR:  res_d = opa | opb;
      OP_XOR: res_d = opa ^ opb;
      OP_NOT: res_d = ~opa;
      OP_SHL: begin
        res_d = {opa[MSB-1:0], 1'b0};
        c_d   = opa[MSB];
      end
      OP_SHR: begin
        res_d = {1'b0, opa[MSB:1]};
        c_d   = opa[0];
      end
      OP_LOAD: begin
        res_d   = bus.mData;
        ccupd_d = 1'b0;
      end
      OP_MOV: begin
        res_d   = opa;
        ccupd_d = 1'b0;
      end
      default: begin
        wr_d    = 1'b0;
        ccupd_d = 1'b0;
      end
    endcase
    flags_d = {res_d[MSB], (res_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_wr_q    <= 1'b0;
      e_ccupd_q <= 1'b0;
      e_rd_q    <= '0;
      e_res_q   <= '0;
      e_flags_q <= '0;
    end else begin
      e_valid_q <= bus.in_valid;
      e_wr_q    <= bus.in_valid && wr_d && !const_dst;
      e_ccupd_q <= bus.in_valid && ccupd_d;
      e_rd_q    <= bus.Rbus;
      e_res_q   <= res_d;
      e_flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= '{default: '0};
      r_q[ONE_IDX] <= DATA_W'(1);
    end else if (e_wr_q) begin
      r_q[e_rd_q]  <= e_res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= e_valid_q;
      if (e_ccupd_q) cc_q <= e_flags_q;
    end
  end

  always_comb begin
    bus.Kbus = '0;
    for (int unsigned k = 0; k < K_REGS; k++) begin
      bus.Kbus[DATA_W*(K_REGS-k)-1 -: DATA_W] = r_q[AW'(K_BASE + k)];
    end
  end

  assign bus.cc        = cc_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_dpu_pipe.sv
// Directed bench for dpu_pipe: register contents are observed through Kbus
// by MOVing them into R9..R11.
module tb_dpu_pipe;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned K_REGS = 3;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, SHR = 4'd7,
                         LOAD = 4'd8, MOV = 4'd9, NOP = 4'd12;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  dpu_pipe_if #(.DATA_W(DATA_W), .AW(AW), .K_REGS(K_REGS)) bus ();

  dpu_pipe #(
    .DATA_W(DATA_W), .NREG(16), .K_BASE(9), .K_REGS(K_REGS),
    .ZERO_IDX(13), .ONE_IDX(12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v)
      else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] r, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.n        = op;
    bus.Abus     = a;
    bus.Bbus     = b;
    bus.Rbus     = r;
    bus.mData    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.n = '0; bus.Abus = '0; bus.Bbus = '0; bus.Rbus = '0; bus.mData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_kbus", 32'(bus.Kbus), 32'h000000);
    chk("rst_cc",   32'(bus.cc), 32'h0);
    chk("rst_ov",   32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;

    // R12 resets to 1
    issue(MOV, 4'd12, 4'd0, 4'd9, 8'h00);
    idle();
    chk("r12_one_ov",   32'(bus.out_valid), 32'h1);
    chk("r12_one_kbus", 32'(bus.Kbus), 32'h010000);
    idle();
    chk("idle_no_ov", 32'(bus.out_valid), 32'h0);

    // reset while a LOAD to R9 sits in E
    issue(LOAD, 4'd0, 4'd0, 4'd9, 8'h77);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_kbus", 32'(bus.Kbus), 32'h000000);
    chk("midrst_ov",   32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    idle();
    idle();
    chk("midrst_kbus2", 32'(bus.Kbus), 32'h000000);
    chk("midrst_ov2",   32'(bus.out_valid), 32'h0);

    // three back-to-back loads into the Kbus window
    issue(LOAD, 4'd0, 4'd0, 4'd9,  8'hAB);
    issue(LOAD, 4'd0, 4'd0, 4'd10, 8'hCD);
    chk("ld1_ov",   32'(bus.out_valid), 32'h1);
    chk("ld1_kbus", 32'(bus.Kbus), 32'hAB0000);
    issue(LOAD, 4'd0, 4'd0, 4'd11, 8'hEF);
    chk("ld2_ov",   32'(bus.out_valid), 32'h1);
    chk("ld2_kbus", 32'(bus.Kbus), 32'hABCD00);
    idle();
    chk("ld3_ov",   32'(bus.out_valid), 32'h1);
    chk("ld3_kbus", 32'(bus.Kbus), 32'hABCDEF);
    idle();
    chk("ld_end_ov", 32'(bus.out_valid), 32'h0);

    // forwarding into ADD, then SUB from constants
    issue(LOAD, 4'd0,  4'd0,  4'd0, 8'hFF);
    issue(ADD,  4'd0,  4'd12, 4'd1, 8'h00);
    issue(SUB,  4'd13, 4'd12, 4'd2, 8'h00);
    chk("add_fwd_cc", 32'(bus.cc), 32'b0110);
    idle();
    chk("sub_cc", 32'(bus.cc), 32'b1010);
    issue(MOV, 4'd1, 4'd0, 4'd9,  8'h00);
    issue(MOV, 4'd2, 4'd0, 4'd10, 8'h00);
    idle();
    chk("add_sub_kbus", 32'(bus.Kbus), 32'h00FFEF);
    issue(NOP, 4'd0, 4'd0, 4'd9, 8'h99);
    idle();
    chk("nop_ov",   32'(bus.out_valid), 32'h1);
    chk("nop_cc",   32'(bus.cc), 32'b1010);
    chk("nop_kbus", 32'(bus.Kbus), 32'h00FFEF);

    // signed overflow, SHR carry, AND clears C
    issue(LOAD, 4'd0, 4'd0, 4'd3, 8'h7F);
    issue(LOAD, 4'd0, 4'd0, 4'd4, 8'h01);
    issue(ADD,  4'd3, 4'd4, 4'd5, 8'h00);
    idle();
    chk("ovf_cc", 32'(bus.cc), 32'b1001);
    issue(MOV, 4'd5, 4'd0, 4'd11, 8'h00);
    idle();
    chk("ovf_kbus",  32'(bus.Kbus), 32'h00FF80);
    chk("mov_hold_cc", 32'(bus.cc), 32'b1001);
    issue(SHR, 4'd4, 4'd0, 4'd6, 8'h00);
    idle();
    chk("shr_cc", 32'(bus.cc), 32'b0110);
    issue(AND_, 4'd3, 4'd4, 4'd7, 8'h00);
    idle();
    chk("and_cc", 32'(bus.cc), 32'b0000);
    issue(MOV, 4'd6, 4'd0, 4'd9,  8'h00);
    issue(MOV, 4'd7, 4'd0, 4'd10, 8'h00);
    idle();
    chk("shr_and_kbus", 32'(bus.Kbus), 32'h000180);

    // constant registers ignore writes and are never forwarded
    issue(LOAD, 4'd0,  4'd0,  4'd12, 8'h55);
    issue(LOAD, 4'd0,  4'd0,  4'd13, 8'h33);
    issue(ADD,  4'd12, 4'd13, 4'd3,  8'h00);
    issue(SUB,  4'd13, 4'd12, 4'd12, 8'h00);
    chk("const_add_cc", 32'(bus.cc), 32'b0000);
    issue(MOV, 4'd12, 4'd0, 4'd9, 8'h00);
    chk("const_sub_cc", 32'(bus.cc), 32'b1010);
    issue(MOV, 4'd13, 4'd0, 4'd10, 8'h00);
    issue(MOV, 4'd3,  4'd0, 4'd11, 8'h00);
    idle();
    chk("const_kbus", 32'(bus.Kbus), 32'h010001);

    // same destination back to back: later value wins
    issue(LOAD, 4'd0, 4'd0, 4'd9, 8'h11);
    issue(LOAD, 4'd0, 4'd0, 4'd9, 8'h22);
    chk("waw_ov1", 32'(bus.out_valid), 32'h1);
    idle();
    chk("waw_ov2",  32'(bus.out_valid), 32'h1);
    chk("waw_kbus", 32'(bus.Kbus), 32'h220001);
    idle();
    chk("waw_ov_end", 32'(bus.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
